pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RA_W, default 5: register-address width.
REQ-002 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have: id_valid  in  1  ID stage holds a valid instruction.
REQ-005 SHALL have: id_rs, id_rt  in  RA_W  ID source register addresses.
REQ-006 SHALL have: id_use_rs, id_use_rt  in  1  ID instruction reads rs / rt.
REQ-007 SHALL have: id_wr_en  in  1, id_wr_addr  in  RA_W  ID destination write enable and address.
REQ-008 SHALL have: id_is_load  in  1  ID instruction is a data-memory load.
REQ-009 SHALL have: ex_br_taken  in  1  branch or jump in EX resolved as taken.
REQ-010 SHALL have: stall  out  1  hold PC and ID; insert an EX bubble.
REQ-011 SHALL have: flush  out  1  squash IF and ID.
REQ-012 SHALL have: fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 MEM-stage ALU result, 10 WB data.
REQ-013 SHALL have: ex_valid, mem_valid, wb_valid  out  1  per-stage valid bits.
REQ-014 SHALL have: stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-015 SHALL keep shadow stages EX, MEM and WB, each holding {valid, rs, rt, use_rs, use_rt, wr_en, wr_addr, is_load}, advancing on every rising clk edge.
REQ-016 SHALL load EX from the ID inputs when stall=0 and flush=0; otherwise EX valid SHALL be 0 (bubble). MEM<=EX and WB<=MEM unconditionally.
REQ-017 SHALL treat a stage as a "writer" only when it has valid=1, wr_en=1 and wr_addr!=0; register 0 SHALL never create a hazard or a forward.
REQ-018 SHALL compute stall combinationally: id_valid AND (id_use_rs matches an EX writer's wr_addr OR id_use_rt matches an EX writer's wr_addr) AND EX.is_load. This is the load-use case and costs exactly 1 bubble.
REQ-019 SHALL compute fwd_a for the EX instruction (rs): 01 if MEM is a writer, MEM.wr_addr==EX.rs and MEM.is_load=0; else 10 if WB is a writer with WB.wr_addr==EX.rs; else 00. Gated by EX.valid and EX.use_rs. fwd_b SHALL be computed the same way using rt.
REQ-020 SHALL give MEM priority over WB when both match the same source register.
REQ-021 SHALL assert flush = ex_br_taken AND ex_valid in the same cycle.
REQ-022 SHALL give flush priority over stall on simultaneous events: stall SHALL be forced to 0 and the ID instruction SHALL be discarded, not held.
REQ-023 SHALL have no latency from inputs to stall, flush or fwd (combinational); stage valids SHALL update one cycle after the ID inputs are presented.
REQ-024 SHALL increment stall_cnt by 1 on each rising edge with stall=1, and SHALL hold the counter at all-ones (no wrap).

Reset
REQ-025 SHALL clear all shadow-stage fields, stall_cnt and all valid bits to 0 on a rising edge with rst=1, which yields stall=0, flush=0, fwd_a=fwd_b=00.
REQ-026 SHALL, when rst is asserted mid-stall or mid-flush, return all outputs to their reset values on the next edge and discard in-flight state.

Configuration
REQ-027 SHALL compile forwarding in when macro PIPE_HAZARD_FWD_EN is defined, with behaviour per REQ-018..REQ-020.
REQ-028 SHALL behave as follows when PIPE_HAZARD_FWD_EN is undefined: fwd_a and fwd_b SHALL be constant 00, and stall SHALL assert while any used ID source matches the wr_addr of an EX or MEM writer, regardless of is_load. WB SHALL not stall (register file is write-through).

Structure
REQ-029 SHALL place the fwd-select encodings (FWD_RF, FWD_MEM, FWD_WB) and the shadow-stage struct typedef in shared package pipe_pkg.
REQ-030 SHALL implement the stage-level source/destination compare as sub-module hazard_cmp, instantiated once per (source, stage) pair.

Verification
REQ-031 SHALL cover: add r3 followed by sub r4,r3,r5 (FWD on) -> no stall; fwd_a=01 in the sub's EX cycle.
REQ-032 SHALL cover: add r3, nop, then use r3 -> fwd=10; with add r3 in both MEM and WB, fwd=01.
REQ-033 SHALL cover: lw r2 followed by add r6,r2,r2 -> stall=1 for exactly 1 cycle, then fwd_a=fwd_b=10, stall_cnt=1.
REQ-034 SHALL cover: ex_br_taken=1 in the same cycle as a load-use stall -> flush=1, stall=0, ex_valid=0 next cycle.
REQ-035 SHALL cover: writes to r0 followed by reads of r0 -> never stall, fwd=00; FWD undefined, add r3 then use r3 -> stall 2 cycles.
REQ-036 SHALL cover: CNT_W=4 with 20 forced stall cycles -> stall_cnt=15; rst=1 -> stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: shadow-stage record and forward-select codes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package pipe_pkg;

  // Widest register address the shadow stages can carry; narrower RA_W values are zero-extended.
  localparam int RA_MAX = 8;

  // EX operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [RA_MAX-1:0] rs;
    logic [RA_MAX-1:0] rt;
    logic              use_rs;
    logic              use_rt;
    logic              wr_en;
    logic [RA_MAX-1:0] wr_addr;
    logic              is_load;
  } stage_t;

  // MEM wins over WB (younger value); a load in MEM has no data yet, so it cannot forward.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic mem_is_load,
                                         input logic wb_hit);
    if (mem_hit && !mem_is_load) return FWD_MEM;
    else if (wb_hit)             return FWD_WB;
    else                         return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one source register against one pipeline stage's destination.
// Latency: combinational.
// Backpressure: none.
module hazard_cmp #(
  parameter int W = 5
) (
  input  logic         src_use,
  input  logic [W-1:0] src_addr,
  input  logic         dst_valid,
  input  logic         dst_wr_en,
  input  logic [W-1:0] dst_wr_addr,
  output logic         hit
);

  // r0 is hard-wired to zero, so it is never a real producer
  always_comb begin
    hit = src_use && dst_valid && dst_wr_en && (dst_wr_addr != '0) && (src_addr == dst_wr_addr);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding for a 5-stage in-order pipeline.
// Latency: stall/flush/fwd combinational; shadow stages and stall_cnt update one edge later.
// Backpressure: stall holds PC/ID and bubbles EX; flush overrides stall. PIPE_HAZARD_FWD_EN enables forwarding.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [RA_W-1:0]  id_wr_addr,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_t id_stg, ex_stg, mem_stg, wb_stg;
  logic   stall_raw;
  logic   id_ex_rs_hit, id_ex_rt_hit;

  // Pack the ID inputs into a stage record, zero-extending register addresses
  always_comb begin
    id_stg         = '0;
    id_stg.valid   = id_valid;
    id_stg.rs      = RA_MAX'(id_rs);
    id_stg.rt      = RA_MAX'(id_rt);
    id_stg.use_rs  = id_use_rs;
    id_stg.use_rt  = id_use_rt;
    id_stg.wr_en   = id_wr_en;
    id_stg.wr_addr = RA_MAX'(id_wr_addr);
    id_stg.is_load = id_is_load;
  end

  hazard_cmp #(.W(RA_MAX)) u_id_ex_rs (
    .src_use(id_stg.use_rs), .src_addr(id_stg.rs),
    .dst_valid(ex_stg.valid), .dst_wr_en(ex_stg.wr_en), .dst_wr_addr(ex_stg.wr_addr),
    .hit(id_ex_rs_hit)
  );
  hazard_cmp #(.W(RA_MAX)) u_id_ex_rt (
    .src_use(id_stg.use_rt), .src_addr(id_stg.rt),
    .dst_valid(ex_stg.valid), .dst_wr_en(ex_stg.wr_en), .dst_wr_addr(ex_stg.wr_addr),
    .hit(id_ex_rt_hit)
  );

`ifdef PIPE_HAZARD_FWD_EN
  logic ex_mem_rs_hit, ex_mem_rt_hit, ex_wb_rs_hit, ex_wb_rt_hit;

  hazard_cmp #(.W(RA_MAX)) u_ex_mem_rs (
    .src_use(ex_stg.use_rs), .src_addr(ex_stg.rs),
    .dst_valid(mem_stg.valid), .dst_wr_en(mem_stg.wr_en), .dst_wr_addr(mem_stg.wr_addr),
    .hit(ex_mem_rs_hit)
  );
  hazard_cmp #(.W(RA_MAX)) u_ex_mem_rt (
    .src_use(ex_stg.use_rt), .src_addr(ex_stg.rt),
    .dst_valid(mem_stg.valid), .dst_wr_en(mem_stg.wr_en), .dst_wr_addr(mem_stg.wr_addr),
    .hit(ex_mem_rt_hit)
  );
  hazard_cmp #(.W(RA_MAX)) u_ex_wb_rs (
    .src_use(ex_stg.use_rs), .src_addr(ex_stg.rs),
    .dst_valid(wb_stg.valid), .dst_wr_en(wb_stg.wr_en), .dst_wr_addr(wb_stg.wr_addr),
    .hit(ex_wb_rs_hit)
  );
  hazard_cmp #(.W(RA_MAX)) u_ex_wb_rt (
    .src_use(ex_stg.use_rt), .src_addr(ex_stg.rt),
    .dst_valid(wb_stg.valid), .dst_wr_en(wb_stg.wr_en), .dst_wr_addr(wb_stg.wr_addr),
    .hit(ex_wb_rt_hit)
  );

  // Only a load in EX cannot be forwarded in time: one bubble covers it
  always_comb begin
    stall_raw = id_valid && (id_ex_rs_hit || id_ex_rt_hit) && ex_stg.is_load;
  end

  // Pick the youngest available producer for each EX operand
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_stg.valid) begin
      fwd_a = fwd_sel(ex_mem_rs_hit, mem_stg.is_load, ex_wb_rs_hit);
      fwd_b = fwd_sel(ex_mem_rt_hit, mem_stg.is_load, ex_wb_rt_hit);
    end
  end
`else
  logic id_mem_rs_hit, id_mem_rt_hit;

  hazard_cmp #(.W(RA_MAX)) u_id_mem_rs (
    .src_use(id_stg.use_rs), .src_addr(id_stg.rs),
    .dst_valid(mem_stg.valid), .dst_wr_en(mem_stg.wr_en), .dst_wr_addr(mem_stg.wr_addr),
    .hit(id_mem_rs_hit)
  );
  hazard_cmp #(.W(RA_MAX)) u_id_mem_rt (
    .src_use(id_stg.use_rt), .src_addr(id_stg.rt),
    .dst_valid(mem_stg.valid), .dst_wr_en(mem_stg.wr_en), .dst_wr_addr(mem_stg.wr_addr),
    .hit(id_mem_rt_hit)
  );

  // Without bypass paths, wait until the producer reaches WB (register file writes through)
  always_comb begin
    stall_raw = id_valid && (id_ex_rs_hit || id_ex_rt_hit || id_mem_rs_hit || id_mem_rt_hit);
  end

  // Operands always come from the register file
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
  end
`endif

  // A taken branch squashes the ID instruction, so there is nothing left to hold
  always_comb begin
    flush = ex_br_taken && ex_stg.valid;
    stall = stall_raw && !flush;
  end

  // Shadow pipeline: EX takes ID unless stalled/flushed, the rest shift every edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_stg  <= '0;
      mem_stg <= '0;
      wb_stg  <= '0;
    end else begin
      ex_stg  <= (stall || flush) ? '0 : id_stg;
      mem_stg <= ex_stg;
      wb_stg  <= mem_stg;
    end
  end

  // Saturating count of stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ex_valid  = ex_stg.valid;
    mem_valid = mem_stg.valid;
    wb_valid  = wb_stg.valid;
  end

  // Several record fields are carried only so the stages read naturally in waveforms
  logic unused_bits;
  assign unused_bits = ^{ex_stg, mem_stg, wb_stg};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [RA_W-1:0]  id_rs, id_rt, id_wr_addr;
  logic             id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic             ex_br_taken;
  logic             stall, flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             ex_valid, mem_valid, wb_valid;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int nst;
  int exp_cnt;

  pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one ID instruction and let combinational outputs settle
  task automatic drive(input logic v, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                       input logic urs, input logic urt, input logic we,
                       input logic [RA_W-1:0] wa, input logic ld);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_use_rs  = urs;
    id_use_rt  = urt;
    id_wr_en   = we;
    id_wr_addr = wa;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_br_taken = 1'b0;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state
    rst = 1'b1;
    ex_br_taken = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("rst_stall", 32'(stall), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_fwd_b", 32'(fwd_b), 0);
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_cnt", 32'(stall_cnt), 0);

    // ---------------- add r3,r1,r2 ; sub r4,r3,r5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    check("a_prod_stall", 32'(stall), 0);
    tick();
    check("a_ex_valid", 32'(ex_valid), 1);
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0);
`ifdef PIPE_HAZARD_FWD_EN
    check("a_stall", 32'(stall), 0);
    tick();
    idle();
    check("a_fwd_a", 32'(fwd_a), 1);
    check("a_fwd_b", 32'(fwd_b), 0);
    check("a_cnt", 32'(stall_cnt), 0);
`else
    check("a_stall1", 32'(stall), 1);
    tick();
    check("a_stall2", 32'(stall), 1);
    check("a_bubble", 32'(ex_valid), 0);
    tick();
    check("a_stall3", 32'(stall), 0);
    tick();
    idle();
    check("a_sub_in_ex", 32'(ex_valid), 1);
    check("a_fwd_a", 32'(fwd_a), 0);
    check("a_cnt", 32'(stall_cnt), 2);
`endif

`ifdef PIPE_HAZARD_FWD_EN
    // ---------------- add r3 ; nop ; use r3  -> WB forward
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    check("b_stall", 32'(stall), 0);
    tick();
    idle();
    check("b_fwd_a_wb", 32'(fwd_a), 2);
    check("b_fwd_b_rf", 32'(fwd_b), 0);
    // add r3 ; add r3 ; use r3,r3 -> MEM beats WB
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    tick();
    idle();
    check("b_fwd_a_mem", 32'(fwd_a), 1);
    check("b_fwd_b_mem", 32'(fwd_b), 1);
`endif

    // ---------------- lw r2 ; add r6,r2,r2
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    check("c_stall1", 32'(stall), 1);
    tick();
`ifdef PIPE_HAZARD_FWD_EN
    check("c_stall2", 32'(stall), 0);
    check("c_bubble", 32'(ex_valid), 0);
    tick();
    idle();
    check("c_fwd_a", 32'(fwd_a), 2);
    check("c_fwd_b", 32'(fwd_b), 2);
    check("c_cnt", 32'(stall_cnt), 1);
`else
    check("c_stall2", 32'(stall), 1);
    check("c_bubble", 32'(ex_valid), 0);
    tick();
    check("c_stall3", 32'(stall), 0);
    tick();
    idle();
    check("c_fwd_a", 32'(fwd_a), 0);
    check("c_fwd_b", 32'(fwd_b), 0);
    check("c_cnt", 32'(stall_cnt), 2);
`endif
    check("c_add_in_ex", 32'(ex_valid), 1);

    // ---------------- branch taken during a load-use stall
    do_reset();
    ex_br_taken = 1'b1;
    idle();
    check("d_flush_empty_ex", 32'(flush), 0);
    ex_br_taken = 1'b0;
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    ex_br_taken = 1'b1;
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    check("d_flush", 32'(flush), 1);
    check("d_stall_masked", 32'(stall), 0);
    tick();
    ex_br_taken = 1'b0;
    idle();
    check("d_ex_valid", 32'(ex_valid), 0);
    check("d_mem_valid", 32'(mem_valid), 1);
    check("d_cnt", 32'(stall_cnt), 0);

    // ---------------- r0 never hazards or forwards
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0);
    check("e_r0_stall", 32'(stall), 0);
    tick();
    idle();
    check("e_r0_fwd_a", 32'(fwd_a), 0);
    check("e_r0_fwd_b", 32'(fwd_b), 0);
    check("e_r0_cnt", 32'(stall_cnt), 0);

    // ---------------- reset in the middle of a stall
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1);
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    check("f_stall_pre", 32'(stall), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("f_stall_post", 32'(stall), 0);
    check("f_ex_valid", 32'(ex_valid), 0);
    check("f_mem_valid", 32'(mem_valid), 0);
    check("f_cnt", 32'(stall_cnt), 0);

    // ---------------- counter saturation: repeated lw r3 ; use r3
    do_reset();
    nst = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1);
      tick();
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0);
      for (int k = 0; k < 4 && stall; k++) begin
        nst++;
        tick();
      end
      check("g_stall_released", 32'(stall), 0);
      tick();
    end
    idle();
    exp_cnt = (nst > 15) ? 15 : nst;
    check("g_stall_cycles_min", 32'(nst >= 20), 1);
    check("g_cnt_sat", 32'(stall_cnt), 32'(exp_cnt));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("g_cnt_rst", 32'(stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
